// File: rtl/serial_adder.sv
// Bit-serial N-bit adder/subtractor: one full_adder cell walked LSB-first across
// the operands, with a registered carry and a start/done handshake.

module full_adder (
  input  logic A,
  input  logic B,
  input  logic C_in,
  output logic R,
  output logic C_out
);
  assign R     = A ^ B ^ C_in;
  assign C_out = (A & B) | (C_in & (A ^ B));
endmodule

module serial_adder #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         C_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] R,
  output logic         C_out,
  output logic         overflow
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   a_sh_q, a_sh_d;
  logic [N-1:0]   b_sh_q, b_sh_d;
  logic [N-1:0]   r_sh_q, r_sh_d;
  logic [N-1:0]   r_q, r_d;
  logic           carry_q, carry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           fa_r, fa_c;

  full_adder u_fa (
    .A     (a_sh_q[0]),
    .B     (b_sh_q[0]),
    .C_in  (carry_q),
    .R     (fa_r),
    .C_out (fa_c)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    r_d     = r_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtract is A + ~B + 1; the +1 rides in on the initial carry.
          a_sh_d  = A;
          b_sh_d  = sub ? ~B : B;
          carry_d = sub ? 1'b1 : C_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = fa_c;
        r_sh_d  = {fa_r, r_sh_q[N-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB.
          r_d     = {fa_r, r_sh_q[N-1:1]};
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      r_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      r_q     <= r_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign R        = r_q;
  assign C_out    = cout_q;
  assign overflow = ovf_q;
endmodule
